eth_frame_gen: RTL and testbench
================================

ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 SHALL have parameter MIN_LEN, default 46, minimum payload length in bytes.
REQ-002 SHALL have parameter MAX_LEN, default 1500, maximum payload length in bytes.
REQ-003 SHALL have parameter IFG_CYCLES, default 3, idle cycles after each frame's last beat.
REQ-004 SHALL have port aclk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_enable  input  1  level; generate frames back-to-back while high.
REQ-007 SHALL have port cfg_dst_mac  input  48  destination MAC; bits [47:40] are the first byte on the wire.
REQ-008 SHALL have port cfg_src_mac  input  48  source MAC; same byte order.
REQ-009 SHALL have port cfg_pkt_len  input  16  requested payload length in bytes.
REQ-010 SHALL have port cfg_force_error  input  1  corrupt payload byte 0 of frames started while high.
REQ-011 SHALL have port m_axis_tdata  output  32  frame bytes; first byte in [7:0].
REQ-012 SHALL have port m_axis_tkeep  output  4  byte enables.
REQ-013 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-014 SHALL have port m_axis_tready  input  1  downstream accept.
REQ-015 SHALL have port m_axis_tlast  output  1  last beat of frame.
REQ-016 SHALL have port pkt_count  output  32  frames fully transferred.

Function
REQ-017 SHALL implement states IDLE, HDR, PAYLOAD, GAP.
REQ-018 IDLE: when cfg_enable=1, SHALL latch all cfg_* inputs, go to HDR, and assert tvalid on the next cycle (1-cycle latency).
REQ-019 Latched L SHALL be cfg_pkt_len clamped to [MIN_LEN, MAX_LEN]; cfg_* changes mid-frame SHALL not affect the current frame.
REQ-020 Frame bytes SHALL be: dst[6], src[6], L as 2 bytes big-endian, then L payload bytes; total T = 14+L bytes, ceil(T/4) beats.
REQ-021 Payload byte i SHALL equal i[7:0] (wraps 0xFF->0x00); if latched force_error=1, byte 0 SHALL be 0xFF instead.
REQ-022 HDR SHALL cover beats 0-3 (beat 3 carries both length bytes and payload bytes 0,1); PAYLOAD covers remaining beats.
REQ-023 tkeep SHALL be 0xF on all non-last beats; on the last beat, 0x1/0x3/0x7/0xF for T mod 4 = 1/2/3/0; unused tdata bytes SHALL be 0.
REQ-024 Once tvalid=1, tvalid/tdata/tkeep/tlast SHALL hold stable until tvalid&&tready; a beat advances only on handshake.
REQ-025 tlast SHALL be 1 only on the final beat; on its handshake pkt_count SHALL increment by 1, wrapping 0xFFFFFFFF->0.
REQ-026 After the tlast handshake, SHALL enter GAP with tvalid=0 for exactly IFG_CYCLES cycles, then IDLE; with IFG_CYCLES=0, SHALL go directly to IDLE.
REQ-027 cfg_enable deassertion mid-frame SHALL not truncate the frame; the frame completes, then the block idles.
REQ-028 tready may be low indefinitely; the block SHALL not drop, duplicate, or reorder beats.

Reset
REQ-029 While aresetn=0, SHALL force state IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0, pkt_count=0, and clear latched config, asynchronously.
REQ-030 Reset asserted mid-frame SHALL abandon the frame (no tlast); after release, the next frame SHALL start from beat 0.

Verification
REQ-031 dst=0xFFFFFFFF1E00, src=0xFFFFA4A52737, len=30, tready=1 -> L=46, 15 beats; beats 0-3 = 0xFFFFFFFF, 0xFFFF001E, 0x3727A5A4, 0x01002E00; last tkeep=0xF; pkt_count=1.
REQ-032 Same config plus force_error=1 -> beat 3 = 0x01FF2E00; all other beats unchanged.
REQ-033 len=47 -> 16 beats, last beat tkeep=0x1, tdata=0x0000002E; len=2000 -> L=1500 (0x05DC), 379 beats, last tkeep=0x3.
REQ-034 tready toggling pseudo-randomly (50%) -> received byte stream identical to the tready=1 run; tvalid never drops without a handshake.
REQ-035 Continuous enable with IFG_CYCLES=3 -> exactly 3 tvalid=0 cycles between tlast handshake and next beat 0; enable dropped at beat 5 -> frame completes, no further frames.
REQ-036 aresetn pulsed low at beat 7 -> tvalid=0 immediately, pkt_count=0; after release with enable=1, a full correct frame is sent.

Source files
------------

// File: rtl/eth_frame_gen.sv
// Ethernet-style frame generator: DST/SRC/length header plus counting payload,
// streamed as 32-bit AXI4-Stream beats, followed by a programmable idle gap.
module eth_frame_gen #(
    parameter int MIN_LEN    = 46,
    parameter int MAX_LEN    = 1500,
    parameter int IFG_CYCLES = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cfg_enable,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [15:0] cfg_pkt_len,
    input  logic        cfg_force_error,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] pkt_count
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP} state_t;

    state_t      r_state, w_next;
    logic [47:0] r_dst, r_src;
    logic [15:0] r_len;
    logic        r_ferr;
    logic [15:0] r_beat;
    logic [15:0] r_gap;
    logic [31:0] r_count;

    logic [15:0] w_len_clamped;
    logic [15:0] w_total;
    logic [15:0] w_last_beat;
    logic        w_valid, w_hs, w_is_last, w_gap_done, w_start;
    logic [111:0] w_hdr;

    always_comb begin
        if (cfg_pkt_len < 16'(MIN_LEN))      w_len_clamped = 16'(MIN_LEN);
        else if (cfg_pkt_len > 16'(MAX_LEN)) w_len_clamped = 16'(MAX_LEN);
        else                                 w_len_clamped = cfg_pkt_len;
    end

    assign w_total     = r_len + 16'd14;
    assign w_last_beat = (w_total - 16'd1) >> 2;
    assign w_valid     = (r_state == S_HDR) || (r_state == S_PAYLOAD);
    assign w_hs        = w_valid && m_axis_tready;
    assign w_is_last   = (r_beat == w_last_beat);
    assign w_gap_done  = (r_state == S_GAP) && (r_gap == 16'd1);
    // The final gap cycle doubles as the IDLE decision so back-to-back frames
    // see exactly IFG_CYCLES invalid cycles rather than IFG_CYCLES+1.
    assign w_start     = cfg_enable && ((r_state == S_IDLE) || w_gap_done);
    assign w_hdr       = {r_dst, r_src, r_len};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (cfg_enable) w_next = S_HDR;
            S_HDR:     if (w_hs && r_beat == 16'd3) w_next = S_PAYLOAD;
            S_PAYLOAD: if (w_hs && w_is_last) w_next = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:     if (w_gap_done) w_next = cfg_enable ? S_HDR : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_dst   <= '0;
            r_src   <= '0;
            r_len   <= '0;
            r_ferr  <= 1'b0;
            r_beat  <= '0;
            r_gap   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_dst  <= cfg_dst_mac;
                r_src  <= cfg_src_mac;
                r_len  <= w_len_clamped;
                r_ferr <= cfg_force_error;
                r_beat <= '0;
            end else if (w_hs) begin
                r_beat <= r_beat + 16'd1;
            end
            if (w_hs && w_is_last) begin
                r_count <= r_count + 32'd1;
                r_gap   <= 16'(IFG_CYCLES);
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap - 16'd1;
            end
        end
    end

    // Beat contents derive purely from registered state, so they hold while stalled.
    always_comb begin
        logic [17:0] k;
        logic [17:0] pi;
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            k  = {r_beat, 2'b00} + 18'(j);
            pi = k - 18'd14;
            if (w_valid && (k < {2'b00, w_total})) begin
                m_axis_tkeep[j] = 1'b1;
                if (k < 18'd14)
                    m_axis_tdata[8*j +: 8] = w_hdr[(4'd13 - k[3:0]) * 8 +: 8];
                else if (pi == 18'd0 && r_ferr)
                    m_axis_tdata[8*j +: 8] = 8'hFF;
                else
                    m_axis_tdata[8*j +: 8] = pi[7:0];
            end
        end
    end

    assign m_axis_tvalid = w_valid;
    assign m_axis_tlast  = w_valid && w_is_last;
    assign pkt_count     = r_count;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: hand-computed header beats, a byte-level
// reference stream, backpressure hold checks, gap timing and mid-frame reset.
module tb_eth_frame_gen;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [47:0] cfg_dst_mac = '0;
    logic [47:0] cfg_src_mac = '0;
    logic [15:0] cfg_pkt_len = '0;
    logic        cfg_force_error = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] pkt_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] cap_d [0:511];
    logic [3:0]  cap_k [0:511];
    logic        cap_l [0:511];

    localparam logic [47:0] DST = 48'hFFFFFFFF1E00;
    localparam logic [47:0] SRC = 48'hFFFFA4A52737;

    eth_frame_gen #(.MIN_LEN(46), .MAX_LEN(1500), .IFG_CYCLES(3)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
        .cfg_pkt_len(cfg_pkt_len), .cfg_force_error(cfg_force_error),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .pkt_count(pkt_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input int k, input logic [47:0] d, input logic [47:0] s,
                                         input int len, input bit fe);
        int p;
        if (k < 6)   return 8'(d >> (8 * (5 - k)));
        if (k < 12)  return 8'(s >> (8 * (11 - k)));
        if (k == 12) return 8'(len >> 8);
        if (k == 13) return 8'(len);
        p = k - 14;
        if (p == 0 && fe) return 8'hFF;
        return 8'(p);
    endfunction

    task automatic start(input logic [47:0] d, input logic [47:0] s, input logic [15:0] len, input bit fe);
        @(negedge aclk);
        cfg_dst_mac = d; cfg_src_mac = s; cfg_pkt_len = len; cfg_force_error = fe;
        cfg_enable = 1'b1;
    endtask

    // Collects handshaked beats; drop_at drops enable (and scrambles cfg) when that
    // beat is presented, rst_at asserts reset when that beat is presented.
    task automatic capture(input int budget, input bit rnd, input int drop_at, input int rst_at,
                           output int nb, output int pre_idle, output bit done);
        bit stall;
        logic [37:0] cur, prev;
        nb = 0; pre_idle = 0; done = 1'b0; stall = 1'b0; prev = '0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge aclk);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cur = {1'b0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (stall) check("hold", 64'(cur), 64'(prev));
            stall = m_axis_tvalid && !m_axis_tready;
            prev  = cur;
            if (!m_axis_tvalid && nb == 0) pre_idle++;
            if (m_axis_tvalid) begin
                if (rst_at >= 0 && nb == rst_at) begin
                    aresetn = 1'b0;
                    #1;
                    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
                    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
                    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
                    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
                    check("rst_pkt_count", 64'(pkt_count), 64'd0);
                    return;
                end
                if (nb == drop_at) begin
                    cfg_enable = 1'b0;
                    cfg_pkt_len = 16'd200; cfg_force_error = 1'b1; cfg_dst_mac = '0;
                end
                if (m_axis_tready) begin
                    cap_d[nb] = m_axis_tdata;
                    cap_k[nb] = m_axis_tkeep;
                    cap_l[nb] = m_axis_tlast;
                    nb++;
                    if (m_axis_tlast) done = 1'b1;
                end
            end
        end
        m_axis_tready = 1'b1;
        if (rst_at < 0) check("frame_done", 64'(done), 64'd1);
    endtask

    task automatic compare(input string tag, input logic [47:0] d, input logic [47:0] s,
                           input int req_len, input bit fe, input int nb);
        int len, total, expb, errs;
        logic [31:0] ed;
        logic [3:0]  ek;
        len   = (req_len < 46) ? 46 : (req_len > 1500) ? 1500 : req_len;
        total = 14 + len;
        expb  = (total + 3) / 4;
        check({tag, "_nbeats"}, 64'(nb), 64'(expb));
        errs = 0;
        for (int b = 0; b < nb && b < 512; b++) begin
            ed = '0; ek = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * b + j < total) begin
                    ek[j] = 1'b1;
                    ed[8*j +: 8] = mbyte(4 * b + j, d, s, len, fe);
                end
            end
            if (cap_d[b] !== ed || cap_k[b] !== ek || cap_l[b] !== (b == expb - 1)) errs++;
        end
        check({tag, "_stream_errs"}, 64'(errs), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
        #1;
    endtask

    initial begin
        int nb, pre, vcnt;
        bit done;

        #12;
        check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset_tdata", 64'(m_axis_tdata), 64'd0);
        check("reset_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("reset_pkt_count", 64'(pkt_count), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        idle(2);

        // Short length clamps to 46, header beats hand-computed
        start(DST, SRC, 16'd30, 1'b0);
        capture(200, 1'b0, 0, -1, nb, pre, done);
        check("t1_latency", 64'(pre), 64'd0);
        check("t1_beat0", 64'(cap_d[0]), 64'hFFFFFFFF);
        check("t1_beat1", 64'(cap_d[1]), 64'hFFFF001E);
        check("t1_beat2", 64'(cap_d[2]), 64'h3727A5A4);
        check("t1_beat3", 64'(cap_d[3]), 64'h01002E00);
        check("t1_last_keep", 64'(cap_k[14]), 64'hF);
        compare("t1", DST, SRC, 30, 1'b0, nb);
        idle(10);
        check("t1_pkt_count", 64'(pkt_count), 64'd1);
        check("t1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);

        start(DST, SRC, 16'd30, 1'b1);
        capture(200, 1'b0, 0, -1, nb, pre, done);
        check("t2_beat3", 64'(cap_d[3]), 64'h01FF2E00);
        compare("t2", DST, SRC, 30, 1'b1, nb);
        idle(10);

        start(DST, SRC, 16'd47, 1'b0);
        capture(200, 1'b0, 0, -1, nb, pre, done);
        check("t3_nbeats", 64'(nb), 64'd16);
        check("t3_last_keep", 64'(cap_k[15]), 64'h1);
        check("t3_last_data", 64'(cap_d[15]), 64'h0000002E);
        compare("t3", DST, SRC, 47, 1'b0, nb);
        idle(10);

        start(DST, SRC, 16'd2000, 1'b0);
        capture(2000, 1'b0, 0, -1, nb, pre, done);
        check("t4_nbeats", 64'(nb), 64'd379);
        check("t4_beat3", 64'(cap_d[3]), 64'h0100DC05);
        check("t4_last_keep", 64'(cap_k[378]), 64'h3);
        compare("t4", DST, SRC, 2000, 1'b0, nb);
        idle(10);
        check("t4_pkt_count", 64'(pkt_count), 64'd4);

        // Random backpressure must not change the byte stream
        start(DST, SRC, 16'd30, 1'b0);
        capture(1000, 1'b1, 0, -1, nb, pre, done);
        compare("t5", DST, SRC, 30, 1'b0, nb);
        idle(10);

        // Back-to-back frames: gap length, then enable dropped mid-frame
        start(DST, SRC, 16'd50, 1'b0);
        capture(200, 1'b0, -1, -1, nb, pre, done);
        compare("t6a", DST, SRC, 50, 1'b0, nb);
        capture(200, 1'b0, 5, -1, nb, pre, done);
        check("t6_gap_cycles", 64'(pre), 64'd3);
        compare("t6b", DST, SRC, 50, 1'b0, nb);
        vcnt = 0;
        repeat (20) begin
            @(negedge aclk); #1;
            if (m_axis_tvalid) vcnt++;
        end
        check("t6_no_more_frames", 64'(vcnt), 64'd0);
        check("t6_pkt_count", 64'(pkt_count), 64'd7);

        // Reset at beat 7, then a clean frame after release
        start(DST, SRC, 16'd60, 1'b0);
        capture(200, 1'b0, -1, 7, nb, pre, done);
        check("t7_aborted_beats", 64'(nb), 64'd7);
        @(negedge aclk);
        aresetn = 1'b1;
        capture(200, 1'b0, 0, -1, nb, pre, done);
        check("t7_restart_latency", 64'(pre), 64'd0);
        compare("t7", DST, SRC, 60, 1'b0, nb);
        idle(10);
        check("t7_pkt_count", 64'(pkt_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
